// File: rtl/eth_pause_pkg.sv
// Shared constants and types for the transmit-side PAUSE frame inserter.
package eth_pause_pkg;

  localparam logic [47:0] PAUSE_DA      = 48'h0180C2000001;
  localparam logic [15:0] PAUSE_ETYPE   = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE  = 16'h0001;
  localparam int          PAUSE_LEN_PAD = 60;
  localparam int          PAUSE_LEN_MIN = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_PAUSE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/eth_pause_frame_gen.sv
// PAUSE frame byte sequencer: byte index plus the header/pad byte multiplexer.
// Output is a function of registered state only (idx and the latched fields
// supplied by the parent), so nothing combinational reaches the MAC from inputs.
module eth_pause_frame_gen
  import eth_pause_pkg::*;
#(
  parameter bit PAD_TO_60 = 1'b1
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic        start_i,
  input  logic        advance_i,
  input  logic [47:0] mac_i,
  input  logic [15:0] quanta_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  localparam logic [5:0] LAST_IDX = PAD_TO_60 ? 6'(PAUSE_LEN_PAD - 1) : 6'(PAUSE_LEN_MIN - 1);

  logic [5:0] idx_q, idx_d;

  assign last_o = (idx_q == LAST_IDX);

  // Next index: restart on frame entry, step on each accepted byte, wrap after the last.
  always_comb begin
    idx_d = idx_q;
    if (start_i)        idx_d = 6'd0;
    else if (advance_i) idx_d = last_o ? 6'd0 : idx_q + 6'd1;
  end

  // Index register; reset mid-frame drops back to byte 0.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) idx_q <= 6'd0;
    else        idx_q <= idx_d;
  end

  // Byte multiplexer: DA, SA, EtherType, opcode, quanta, then zero pad.
  always_comb begin
    byte_o = 8'h00;
    case (idx_q)
      6'd0:  byte_o = PAUSE_DA[47:40];
      6'd1:  byte_o = PAUSE_DA[39:32];
      6'd2:  byte_o = PAUSE_DA[31:24];
      6'd3:  byte_o = PAUSE_DA[23:16];
      6'd4:  byte_o = PAUSE_DA[15:8];
      6'd5:  byte_o = PAUSE_DA[7:0];
      6'd6:  byte_o = mac_i[47:40];
      6'd7:  byte_o = mac_i[39:32];
      6'd8:  byte_o = mac_i[31:24];
      6'd9:  byte_o = mac_i[23:16];
      6'd10: byte_o = mac_i[15:8];
      6'd11: byte_o = mac_i[7:0];
      6'd12: byte_o = PAUSE_ETYPE[15:8];
      6'd13: byte_o = PAUSE_ETYPE[7:0];
      6'd14: byte_o = PAUSE_OPCODE[15:8];
      6'd15: byte_o = PAUSE_OPCODE[7:0];
      6'd16: byte_o = quanta_i[15:8];
      6'd17: byte_o = quanta_i[7:0];
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/eth_pause_tx_inserter.sv
// Frame-boundary arbiter between TX FIFO user frames and locally generated
// 802.3x PAUSE frames. A pending PAUSE wins over queued user traffic but never
// cuts into a user frame that has already started.
module eth_pause_tx_inserter
  import eth_pause_pkg::*;
#(
  parameter bit PAD_TO_60 = 1'b1
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        pause_req,
  input  logic [15:0] pause_quanta,
  input  logic [47:0] cfg_src_mac,
  output logic        pause_busy,
  output logic        pause_sent
);

  tx_state_e   state_q, state_d;
  logic        pending_q, pending_d;
  logic [15:0] quanta_q;
  logic [47:0] mac_lat_q;
  logic [15:0] qnt_lat_q;
  logic        sent_q;

  logic        enter_pause;
  logic        gen_adv;
  logic [7:0]  gen_byte;
  logic        gen_last;

  assign enter_pause = (state_q == ST_IDLE) && pending_q;
  // In PAUSE valid is always high, so a handshake is just ready.
  assign gen_adv     = (state_q == ST_PAUSE) && m_axis_tready;

  eth_pause_frame_gen #(.PAD_TO_60(PAD_TO_60)) u_gen (
    .tx_clk    (tx_clk),
    .tx_rst    (tx_rst),
    .start_i   (enter_pause),
    .advance_i (gen_adv),
    .mac_i     (mac_lat_q),
    .quanta_i  (qnt_lat_q),
    .byte_o    (gen_byte),
    .last_o    (gen_last)
  );

  // Arbitration: pending PAUSE first, user frames otherwise; one IDLE between frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q)          state_d = ST_PAUSE;
        else if (s_axis_tvalid) state_d = ST_PASS;
      end
      ST_PASS:  if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = ST_IDLE;
      ST_PAUSE: if (gen_adv && gen_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A new request always wins over the clear at entry, so a coincident
  // request still produces a follow-up frame.
  always_comb begin
    pending_d = pending_q;
    if (pause_req)        pending_d = 1'b1;
    else if (enter_pause) pending_d = 1'b0;
  end

  // State, request bookkeeping and per-frame field capture.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      quanta_q  <= 16'h0000;
      mac_lat_q <= 48'h0;
      qnt_lat_q <= 16'h0000;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (pause_req) quanta_q <= pause_quanta;
      if (enter_pause) begin
        mac_lat_q <= cfg_src_mac;
        qnt_lat_q <= quanta_q;
      end
      sent_q    <= gen_adv && gen_last;
    end
  end

  // Output steering: pass-through in PASS, generator in PAUSE, quiet in IDLE.
  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_PASS: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
      end
      ST_PAUSE: begin
        m_axis_tdata  = gen_byte;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = gen_last;
      end
      default: ;
    endcase
  end

  assign pause_busy = pending_q | (state_q == ST_PAUSE);
  assign pause_sent = sent_q;

endmodule

// File: tb/tb_eth_pause_tx_inserter.sv
// Scoreboard bench for eth_pause_tx_inserter: expected output beats are queued
// when stimulus is driven and popped as the MAC side accepts them.
module tb_eth_pause_tx_inserter;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        pause_req = 1'b0;
  logic [15:0] pause_quanta = 16'h0000;
  logic [47:0] cfg_src_mac = 48'h020000000001;
  logic        pause_busy;
  logic        pause_sent;

  eth_pause_tx_inserter dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .pause_req     (pause_req),
    .pause_quanta  (pause_quanta),
    .cfg_src_mac   (cfg_src_mac),
    .pause_busy    (pause_busy),
    .pause_sent    (pause_sent)
  );

  always #5 tx_clk = ~tx_clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    sent_cnt = 0;
  int    fr_pos = 0;
  int    last_end_cyc = 0;
  int    last_gap = 0;
  beat_t exp_q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  always @(posedge tx_clk) cyc++;

  // Output monitor: scoreboard compare, hold-under-stall check, pulse counting.
  always @(negedge tx_clk) begin
    beat_t e;
    if (tx_rst) begin
      fr_pos = 0;
      prev_stall = 1'b0;
    end else begin
      if (pause_sent) sent_cnt++;
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_beat.d || m_axis_tlast !== prev_beat.l) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%02h l=%b, need v=1 d=%02h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_beat.d, prev_beat.l);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%02h l=%b, need no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
            errors++;
            $display("FAIL beat_%0d: got d=%02h l=%b u=%b, need d=%02h l=%b u=%b",
                     fr_pos, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
          end
        end
        if (fr_pos == 0) last_gap = cyc - last_end_cyc;
        if (m_axis_tlast) begin
          last_end_cyc = cyc;
          fr_pos = 0;
        end else fr_pos++;
      end
    end
  end

  // Queue the full expected PAUSE frame (60 bytes, zero pad).
  task automatic push_pause(input logic [47:0] mac, input logic [15:0] q);
    logic [7:0] hdr [18];
    hdr = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01,
            mac[47:40], mac[39:32], mac[31:24], mac[23:16], mac[15:8], mac[7:0],
            8'h88, 8'h08, 8'h00, 8'h01, q[15:8], q[7:0]};
    for (int i = 0; i < 60; i++)
      exp_q.push_back('{d: (i < 18) ? hdr[i] : 8'h00, l: (i == 59), u: 1'b0});
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge tx_clk); #1;
      k++;
    end
    repeat (3) begin @(posedge tx_clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats left, need 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive one user frame; optional PAUSE requests at byte positions ra / rb.
  task automatic send_user(input int n, input int ra, input logic [15:0] qa,
                           input int rb, input logic [15:0] qb);
    logic acc;
    int   k;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = 8'(i * 7 + 3);
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = (i == n - 1) && (n % 2 == 1);
      s_axis_tvalid = 1'b1;
      exp_q.push_back('{d: s_axis_tdata, l: s_axis_tlast, u: s_axis_tuser});
      if (i == ra) begin pause_req = 1'b1; pause_quanta = qa; end
      if (i == rb) begin pause_req = 1'b1; pause_quanta = qb; end
      k = 0;
      forever begin
        @(negedge tx_clk);
        acc = s_axis_tready;
        @(posedge tx_clk); #1;
        pause_req = 1'b0;
        if (acc) break;
        k++;
        if (k > 200) begin
          checks++; errors++;
          $display("FAIL user_accept_timeout: got no tready at byte %0d, need tready", i);
          break;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (rb >= 0)      push_pause(cfg_src_mac, qb);
    else if (ra >= 0) push_pause(cfg_src_mac, qa);
  endtask

  task automatic test_reset();
    tx_rst = 1'b1;
    #3;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready, pause_busy, pause_sent} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%02h l=%b u=%b rdy=%b busy=%b sent=%b, need all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready, pause_busy, pause_sent);
    end
    @(negedge tx_clk); #2 tx_rst = 1'b0;
    repeat (2) begin @(posedge tx_clk); #1; end
    checks++;
    if ({m_axis_tvalid, s_axis_tready, pause_busy, pause_sent} !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got v=%b rdy=%b busy=%b sent=%b, need 0",
               m_axis_tvalid, s_axis_tready, pause_busy, pause_sent);
    end
  endtask

  task automatic test_basic_pause();
    int s0 = sent_cnt;
    m_axis_tready = 1'b1;
    pause_quanta = 16'hFFFF; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'hFFFF);
    @(posedge tx_clk); #1; pause_req = 1'b0;
    checks++;
    if (pause_busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_n1: got busy=%b v=%b, need busy=1 v=0", pause_busy, m_axis_tvalid);
    end
    @(posedge tx_clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01) begin
      errors++;
      $display("FAIL basic_n2_byte0: got v=%b d=%02h, need v=1 d=01", m_axis_tvalid, m_axis_tdata);
    end
    repeat (60) begin @(posedge tx_clk); #1; end
    checks++;
    if (pause_sent !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_n62_sent: got sent=%b v=%b, need sent=1 v=0", pause_sent, m_axis_tvalid);
    end
    @(posedge tx_clk); #1;
    checks++;
    if (pause_sent !== 1'b0 || pause_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_n63_quiet: got sent=%b busy=%b, need 0 0", pause_sent, pause_busy);
    end
    wait_drain("basic");
    checks++;
    if (sent_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_sent_count: got %0d, need 1", sent_cnt - s0);
    end
  endtask

  task automatic test_no_preempt();
    int s0 = sent_cnt;
    send_user(100, 10, 16'h1234, -1, 16'h0000);
    wait_drain("no_preempt");
    checks++;
    if (last_gap != 2) begin
      errors++;
      $display("FAIL no_preempt_gap: got %0d cycles last-to-first, need 2", last_gap);
    end
    checks++;
    if (sent_cnt - s0 != 1) begin
      errors++;
      $display("FAIL no_preempt_sent: got %0d, need 1", sent_cnt - s0);
    end
  endtask

  task automatic test_priority();
    pause_quanta = 16'h5A5A; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'h5A5A);
    @(posedge tx_clk); #1; pause_req = 1'b0;
    send_user(8, -1, 16'h0000, -1, 16'h0000);
    wait_drain("priority");
  endtask

  task automatic test_coalesce();
    int s0 = sent_cnt;
    send_user(20, 3, 16'h0010, 6, 16'h0020);
    wait_drain("coalesce");
    checks++;
    if (sent_cnt - s0 != 1) begin
      errors++;
      $display("FAIL coalesce_sent: got %0d, need 1", sent_cnt - s0);
    end
  endtask

  // Second request lands on the PAUSE entry cycle: two frames, one bubble apart.
  task automatic test_back_to_back();
    int s0 = sent_cnt;
    pause_quanta = 16'h0A0A; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'h0A0A);
    @(posedge tx_clk); #1;
    pause_quanta = 16'h0B0B;
    push_pause(cfg_src_mac, 16'h0B0B);
    @(posedge tx_clk); #1; pause_req = 1'b0;
    wait_drain("back_to_back");
    checks++;
    if (sent_cnt - s0 != 2 || last_gap != 2) begin
      errors++;
      $display("FAIL back_to_back: got sent=%0d gap=%0d, need sent=2 gap=2", sent_cnt - s0, last_gap);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    pause_quanta = 16'hFFFF; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'hFFFF);
    m_axis_tready = 1'($urandom_range(0, 1));
    @(posedge tx_clk); #1; pause_req = 1'b0;
    while (exp_q.size() != 0 && k < 2000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge tx_clk); #1;
      k++;
    end
    m_axis_tready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int s0;
    pause_quanta = 16'h7777; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'h7777);
    @(posedge tx_clk); #1; pause_req = 1'b0;
    while (fr_pos != 30 && k < 200) begin @(posedge tx_clk); #1; k++; end
    checks++;
    if (fr_pos != 30) begin
      errors++;
      $display("FAIL reset_mid_reach: got pos %0d, need 30", fr_pos);
    end
    s0 = sent_cnt;
    tx_rst = 1'b1;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, pause_busy, pause_sent} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b d=%02h l=%b rdy=%b busy=%b sent=%b, need all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, pause_busy, pause_sent);
    end
    exp_q.delete();
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk); #2 tx_rst = 1'b0;
    repeat (3) begin @(posedge tx_clk); #1; end
    checks++;
    if (m_axis_tvalid !== 1'b0 || pause_busy !== 1'b0 || sent_cnt != s0) begin
      errors++;
      $display("FAIL reset_mid_no_resume: got v=%b busy=%b sent=%0d, need 0 0 0",
               m_axis_tvalid, pause_busy, sent_cnt - s0);
    end
    pause_quanta = 16'h0102; pause_req = 1'b1;
    push_pause(cfg_src_mac, 16'h0102);
    @(posedge tx_clk); #1; pause_req = 1'b0;
    wait_drain("reset_mid_refill");
    checks++;
    if (sent_cnt - s0 != 1) begin
      errors++;
      $display("FAIL reset_mid_sent: got %0d, need 1", sent_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pause();
    test_no_preempt();
    test_priority();
    test_coalesce();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_pause_tx_inserter.md
# eth_pause_tx_inserter

Transmit-side companion to the 1G RGMII MAC receive path: sits in the `tx_clk` domain between the TX FIFO output and the MAC TX AXI-Stream input. It arbitrates at frame boundaries between user frames from the FIFO and locally generated IEEE 802.3x MAC Control PAUSE frames. A requested PAUSE frame takes priority over queued user traffic but never interrupts a user frame already in flight. Emitted frames exclude preamble and FCS; the MAC adds both.

## Interface
Parameters:
- `PAD_TO_60`, default 1: 1 = emit 60-byte PAUSE frame with zero padding; 0 = emit 18 bytes and rely on MAC padding.

Ports:
- `tx_clk`  in  1  transmit clock.
- `tx_rst`  in  1  reset for `tx_clk`, asynchronous, active-high.
- `s_axis_tdata`  in  8  user frame data from TX FIFO.
- `s_axis_tvalid`  in  1  user data valid.
- `s_axis_tready`  out  1  user data accepted.
- `s_axis_tlast`  in  1  last byte of user frame.
- `s_axis_tuser`  in  1  user frame bad/abort marker, passed through unchanged.
- `m_axis_tdata`  out  8  data to MAC TX.
- `m_axis_tvalid`  out  1  valid to MAC TX.
- `m_axis_tready`  in  1  MAC TX ready.
- `m_axis_tlast`  out  1  last byte to MAC.
- `m_axis_tuser`  out  1  bad-frame marker to MAC; always 0 for PAUSE frames.
- `pause_req`  in  1  single-cycle request; samples `pause_quanta`.
- `pause_quanta`  in  16  pause time in 512-bit-time quanta.
- `cfg_src_mac`  in  48  station address; byte 47:40 is transmitted first.
- `pause_busy`  out  1  a request is pending or a PAUSE frame is in transmission.
- `pause_sent`  out  1  one-cycle pulse when the last PAUSE byte is accepted.

## Operation
- **State machine** (`IDLE`, `PASS`, `PAUSE`):
  - `IDLE` -> `PAUSE` if `pending`, else -> `PASS` if `s_axis_tvalid`.
  - `PASS` -> `IDLE` on accepted user `tlast`.
  - `PAUSE` -> `IDLE` on accepted final byte.
- **IDLE:** `m_axis_tvalid=0`, `s_axis_tready=0`.
- **PASS:** combinational pass-through. `m_axis_*` = `s_axis_*`; `s_axis_tready` = `m_axis_tready`.
- **PAUSE:** 6-bit byte index `idx`, starting at 0, increments on each `m_axis_tvalid & m_axis_tready`.
  - Bytes 0-5: `01 80 C2 00 00 01`.
  - Bytes 6-11: source MAC latched at PAUSE entry.
  - Bytes 12-13: `88 08`.
  - Bytes 14-15: `00 01`.
  - Bytes 16-17: quanta (MSB first).
  - Bytes 18-59: `00`.
  - `tlast` on byte 59 (`PAD_TO_60=1`) or byte 17 (`PAD_TO_60=0`).
  - `m_axis_tvalid=1` throughout; no bubbles of its own. `s_axis_tready=0`.
- **Pending flag and quanta:**
  - `pause_req` sets `pending` and stores `pause_quanta` into `quanta_reg`.
  - A later `pause_req` while pending overwrites `quanta_reg`; only one frame is sent.
  - Entering `PAUSE` clears `pending` and copies `quanta_reg` and `cfg_src_mac` into frame registers. These are stable for the whole frame.
  - `pause_req` during `PAUSE` sets `pending` again; a second PAUSE frame follows.
  - `pause_req` coincident with PAUSE entry: `pending` remains set and the new quanta are stored.
- **Status outputs:**
  - `pause_busy = pending | (state==PAUSE)`.
  - `pause_sent` is registered and asserts in the cycle after the final byte handshake.
- **Reset** (async, any state): state `IDLE`, `pending=0`, `idx=0`, `quanta_reg=0`, `pause_sent=0`.
  - All outputs are 0 during and after reset.
  - A frame truncated by reset is not resumed.

## Timing
- `pause_req` in cycle N: `pending` and `pause_busy` high at N+1.
- From `IDLE`: state `PAUSE` and byte 0 valid at N+2.
- With `m_axis_tready` held high, 60 bytes are emitted in consecutive cycles; `pause_sent` is high at N+62.
- Exactly one `IDLE` cycle between any two frames: zero throughput penalty beyond one bubble per frame.
- In `PAUSE`, `m_axis_*` come from registers (state, `idx`, latched fields) only; no input-to-output combinational path.
- In `PASS`, there is a zero-latency combinational path `s_axis` <-> `m_axis`.
- Backpressure: `idx` holds while `m_axis_tready=0`; data is stable under valid.

## Structure
- Package `eth_pause_pkg` holds:
  - DA constant `48'h0180C2000001`
  - EtherType `16'h8808`
  - opcode `16'h0001`
  - frame lengths 60/18
  - state encoding
- One sub-module: `eth_pause_frame_gen`. It contains `idx` plus the byte multiplexer; inputs are start, advance, latched MAC and quanta; outputs are byte, last. The top level keeps the arbitration FSM and `pending`.

## Test plan
- **Basic PAUSE:** reset, `cfg_src_mac=02:00:00:00:00:01`, `pause_req` with quanta `0xFFFF`, ready high -> 60 bytes `01 80 C2 00 00 01 02 00 00 00 00 01 88 08 00 01 FF FF` + 42×`00`, `tlast` on byte 59, `pause_sent` one cycle later.
- **No preemption:** user 100-byte frame in progress, `pause_req` at byte 10 -> all 100 user bytes unbroken, then one `IDLE` cycle, then PAUSE frame.
- **Priority and coalescing:**
  - `pause_req` and `s_axis_tvalid` both present in `IDLE` -> PAUSE frame first, user frame second.
  - Two requests (quanta `0x0010` then `0x0020`) before PAUSE entry -> one frame carrying `0x0020`.
- **Backpressure:** random `m_axis_tready` at 50% -> byte sequence identical to the basic case, no duplicates or skips; `tuser` always 0.
- **Reset mid-frame:** `tx_rst` at PAUSE byte 30 -> outputs 0 immediately, `pause_busy=0`; the next request yields a complete 60-byte frame from byte 0.
